// File: rtl/banner_sequencer.sv
// Scrolling 10-nibble banner on a 4-position multiplexed hex display.
// Optional macro BANNER_BLANK_CODE_EN: window nibble 4'hF renders as a blank position.
module banner_sequencer #(
  parameter int TICK_DIV = 10_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [39:0] load_data,
  output logic        load_ready,
  input  logic        run,
  input  logic        dir,
  output logic [3:0]  an,
  output logic [3:0]  digit,
  output logic        step_pulse
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t        state;
  logic [39:0]   word;
  logic [TW-1:0] step_cnt;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    sel;

  // A message may only be swapped while rotation is not active.
  assign load_ready = (state != RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      word       <= '0;
      step_cnt   <= '0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid) begin
            word     <= load_data;
            step_cnt <= '0;
            state    <= run ? RUN : HOLD;
          end
        end
        RUN: begin
          // A step on the same edge that run falls still completes.
          if (step_cnt == TW'(TICK_DIV - 1)) begin
            step_cnt   <= '0;
            step_pulse <= 1'b1;
            word       <= dir ? {word[3:0], word[39:4]} : {word[35:0], word[39:36]};
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
          if (!run) state <= HOLD;
        end
        HOLD: begin
          if (load_valid) begin
            word     <= load_data;
            step_cnt <= '0;
            state    <= run ? RUN : HOLD;
          end else if (run) begin
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Display scan runs independently of the rotation state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      sel      <= 2'd0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      sel      <= sel + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  logic [15:0] window;
  logic [3:0]  nib;

  assign window = word[39:24];
  assign nib    = window[{sel, 2'b00} +: 4];

  always_comb begin
    an    = 4'b1111;
    digit = 4'h0;
    if (state != IDLE) begin
      an    = ~(4'b0001 << sel);
      digit = nib;
`ifdef BANNER_BLANK_CODE_EN
      if (nib == 4'hF) begin
        an    = 4'b1111;
        digit = 4'h0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_banner_sequencer.sv
// Scoreboard bench for banner_sequencer: stimulus pushes expected outputs per cycle,
// a monitor pops and compares after each rising edge.
module tb_banner_sequencer;

  localparam int TD = 4;
  localparam int SD = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic [39:0] load_data = '0;
  logic        run = 1'b0;
  logic        dir = 1'b0;
  logic        load_ready;
  logic [3:0]  an;
  logic [3:0]  digit;
  logic        step_pulse;

  banner_sequencer #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .run(run), .dir(dir), .an(an), .digit(digit),
    .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [9:0] sb_q[$];
  bit armed = 1'b0;

  // Reference model: 0 = no message, 1 = rotating, 2 = paused.
  int          m_mode;
  logic [39:0] m_word;
  int          m_ticks;
  bit          m_pulse;
  int          m_n;

  function automatic logic [39:0] rotate(logic [39:0] w, bit d);
    logic [39:0] r;
    if (d) r = (w >> 4) | (w << 36);
    else   r = (w << 4) | (w >> 36);
    return r;
  endfunction

  function automatic logic [9:0] expect_out();
    int sel;
    logic [3:0] a, dg, nib;
    logic [39:0] sh;
    sel = (m_n / SD) % 4;
    a = 4'hF;
    dg = 4'h0;
    if (m_mode != 0) begin
      sh  = m_word >> (24 + 4 * sel);
      nib = sh[3:0];
      a   = 4'hF ^ (4'h1 << sel);
      dg  = nib;
`ifdef BANNER_BLANK_CODE_EN
      if (nib == 4'hF) begin
        a  = 4'hF;
        dg = 4'h0;
      end
`endif
    end
    return {a, dg, m_pulse, (m_mode != 1)};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_word = '0; m_ticks = 0; m_pulse = 0; m_n = 0;
  endtask

  // Drive one cycle of inputs (called at a falling edge) and queue the expected outputs.
  task automatic cyc(bit lv, logic [39:0] ld, bit r, bit d);
    bit accept;
    load_valid = lv; load_data = ld; run = r; dir = d;
    accept = lv && (m_mode != 1);
    m_pulse = 0;
    m_n++;
    if (m_mode == 1) begin
      m_ticks++;
      if (m_ticks == TD) begin
        m_ticks = 0;
        m_word  = rotate(m_word, d);
        m_pulse = 1;
      end
      if (!r) m_mode = 2;
    end else if (accept) begin
      m_word  = ld;
      m_ticks = 0;
      m_mode  = r ? 1 : 2;
    end else if (m_mode == 2 && r) begin
      m_mode = 1;
    end
    sb_q.push_back(expect_out());
    @(negedge clk);
  endtask

  task automatic do_reset();
    armed = 1'b0;
    reset = 1'b1;
    load_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({an, digit, step_pulse, load_ready} !== 10'b1111_0000_0_1) begin
      errors++;
      $display("FAIL reset_state got an=%b digit=%h pulse=%b ready=%b want an=1111 digit=0 pulse=0 ready=1",
               an, digit, step_pulse, load_ready);
    end
    reset = 1'b0;
    model_reset();
    armed = 1'b1;
  endtask

  initial begin : monitor
    logic [9:0] exp_v;
    forever begin
      @(posedge clk);
      #1;
      if (armed) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty at t=%0t", $time);
        end else begin
          exp_v = sb_q.pop_front();
          if ({an, digit, step_pulse, load_ready} !== exp_v)
            begin
              errors++;
              $display("FAIL outputs t=%0t got an=%b digit=%h pulse=%b ready=%b want an=%b digit=%h pulse=%b ready=%b",
                       $time, an, digit, step_pulse, load_ready,
                       exp_v[9:6], exp_v[5:2], exp_v[1], exp_v[0]);
            end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [39:0] rnd;
    model_reset();
    @(negedge clk);
    do_reset();

    // Idle with no message, run toggled: display stays blank.
    repeat (10) cyc(0, '0, 0, 0);
    repeat (10) cyc(0, '0, 1, 1);

    // Left rotation, then an ignored load while running, then load in HOLD.
    cyc(1, 40'h9876543210, 1, 0);
    repeat (12) cyc(0, '0, 1, 0);
    repeat (3) cyc(1, 40'hABCDE01234, 1, 0);
    cyc(1, 40'hABCDE01234, 0, 0);
    cyc(1, 40'hABCDE01234, 0, 0);
    repeat (10) cyc(0, '0, 0, 0);

    // Right rotation through a full 10-step lap and beyond.
    cyc(1, 40'h9876543210, 1, 1);
    repeat (45) cyc(0, '0, 1, 1);

    // Pause part-way through a tick interval, then resume.
    cyc(0, '0, 0, 0);
    cyc(1, 40'h0123456789, 1, 0);
    cyc(0, '0, 1, 0);
    cyc(0, '0, 0, 0);
    repeat (10) cyc(0, '0, 0, 0);
    repeat (8) cyc(0, '0, 1, 0);

    // Blank-code window, paused so it stays put for a full scan.
    cyc(0, '0, 0, 0);
    cyc(1, 40'hFFF1234567, 0, 0);
    repeat (16) cyc(0, '0, 0, 0);

    // Reset mid-rotation discards the message.
    cyc(1, 40'h1122334455, 1, 0);
    repeat (5) cyc(0, '0, 1, 0);
    do_reset();
    repeat (6) cyc(0, '0, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      rnd = {8'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) == 0) rnd[39:36] = 4'hF;
      if ($urandom_range(0, 399) == 0) do_reset();
      cyc($urandom_range(0, 3) == 0, rnd, $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)));
    end

    armed = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/banner_sequencer.md
BANNER_SEQUENCER -- requirements
Module: banner_sequencer

Interface
REQ-001 TICK_DIV, default 10_000_000, clk cycles per one-nibble rotation step; legal range 2 .. 2^24.
REQ-002 SCAN_DIV, default 50_000, clk cycles each display position stays enabled; legal range 2 .. 2^20.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 load_valid  input  1  a new message is offered on load_data.
REQ-006 load_data  input  40  10-nibble message; digit0 is in [3:0] and digit9 is in [39:36].
REQ-007 load_ready  output  1  the block can accept a message this cycle.
REQ-008 run  input  1  1 = rotate, 0 = freeze rotation.
REQ-009 dir  input  1  0 = rotate left (toward MSB), 1 = rotate right.
REQ-010 an  output  4  active-low position enable; bit3 is the leftmost position.
REQ-011 digit  output  4  hex value for the position currently enabled.
REQ-012 step_pulse  output  1  one-cycle pulse per rotation step.

Function
REQ-013 The FSM SHALL have states IDLE (no message), RUN and HOLD.
REQ-014 A load SHALL be accepted on a clk edge where load_valid=1 and load_ready=1; load_data is captured into the 40-bit word register on that edge.
REQ-015 load_ready SHALL be 1 in IDLE and HOLD, and 0 in RUN; a message can only be replaced while paused.
REQ-016 When a load is accepted, the step counter SHALL clear to 0. The next state is RUN if run=1, otherwise HOLD; this holds from both IDLE and HOLD.
REQ-017 In IDLE with no load, the FSM SHALL stay in IDLE regardless of run.
REQ-018 RUN SHALL go to HOLD when run=0. HOLD SHALL go to RUN when run=1 and no load is accepted.
REQ-019 The step counter SHALL increment only in RUN; it SHALL hold its value in HOLD and be 0 in IDLE.
REQ-020 When the step counter equals TICK_DIV-1 in RUN, it SHALL wrap to 0 on that edge and the word SHALL rotate by one nibble on the same edge.
REQ-021 With dir=0, the rotation SHALL be word <= {word[35:0], word[39:36]}; with dir=1, word <= {word[3:0], word[39:4]}. dir is sampled on the step edge.
REQ-022 If run falls in the same cycle as a step edge, the step SHALL still occur, and the FSM enters HOLD.
REQ-023 step_pulse SHALL be registered: high for exactly the one cycle after each rotation edge, and 0 otherwise.
REQ-024 The visible window SHALL be: position3 = word[39:36], position2 = word[35:32], position1 = word[31:28], position0 = word[27:24].
REQ-025 The scan counter SHALL run freely in all states, counting 0..SCAN_DIV-1 and then wrapping. On each wrap, the 2-bit sel SHALL increment mod 4 (3 -> 0).
REQ-026 In RUN and HOLD, an SHALL equal ~(4'b0001 << sel) and digit SHALL equal the window nibble for position sel.
REQ-027 In IDLE, an SHALL be 4'b1111 and digit SHALL be 4'h0.
REQ-028 an and digit SHALL be combinational decodes of registered state only, with no path from the inputs.

Reset
REQ-029 While reset=1, the block SHALL hold: state=IDLE, word=0, step counter=0, scan counter=0, sel=0, step_pulse=0, an=4'b1111, digit=0, load_ready=1.
REQ-030 Reset asserted mid-rotation or mid-load SHALL discard the message; after release, a new load is required.

Configuration
REQ-031 The macro BANNER_BLANK_CODE_EN SHALL control blank-code handling.
REQ-032 With BANNER_BLANK_CODE_EN defined, a window nibble of 4'hF SHALL be treated as blank: the an bit for its position is forced to 1 and digit is 0 while that position is selected.
REQ-033 Without BANNER_BLANK_CODE_EN, 4'hF SHALL display as an ordinary hex digit.

Verification (TICK_DIV=4, SCAN_DIV=2)
REQ-034 Reset release, then 20 cycles with no load -> an=1111, digit=0, load_ready=1, step_pulse never high.
REQ-035 Load 40'h9876543210 with run=1, dir=0 -> the window reads 9876 until the first step. After 4 cycles it reads 8765, and step_pulse is high once, in the cycle after the step.
REQ-036 Same load with dir=1 -> after one step the window reads 0987; after 10 steps the word is back to 9876543210.
REQ-037 In RUN, drive load_valid=1 with new data -> load_ready=0 and the word is unchanged. Drop run -> HOLD, load_ready=1, the load is accepted and the window shows the new data; no step occurs while in HOLD.
REQ-038 Drop run when the step counter is 2, hold 10 cycles, then raise run -> the next step occurs exactly 2 cycles after RUN is re-entered.
REQ-039 Scan check: sel advances every 2 cycles and an cycles through 1110, 1101, 1011, 0111. With BANNER_BLANK_CODE_EN defined and window nibble FFF1, an=1110 is the only active pattern.
